// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } lsu_state_e;

   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   // Byte accesses are never misaligned; the illegal size is reported separately.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_WORD: mis = (addr_lo != 2'b00);
         SZ_HALF: mis = addr_lo[0];
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/byte-enable placement and load lane
// selection with sign or zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [1:0]  st_addr_lo_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   input  logic [1:0]  ld_size_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic        ld_unsigned_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  ld_byte_s;
   logic [15:0] ld_half_s;

   // Store side: replicate the datum on every lane and enable only the addressed ones.
   always_comb begin
      st_be_o    = 4'b0000;
      st_wdata_o = 32'h0000_0000;
      case (st_size_i)
         SZ_BYTE: begin
            st_be_o    = 4'b0001 << st_addr_lo_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
         end
         SZ_HALF: begin
            st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
            st_wdata_o = {2{st_wdata_i[15:0]}};
         end
         SZ_WORD: begin
            st_be_o    = 4'b1111;
            st_wdata_o = st_wdata_i;
         end
         default: begin
            st_be_o    = 4'b0000;
            st_wdata_o = 32'h0000_0000;
         end
      endcase
   end

   // Load side: pick the addressed lane, then extend to 32 bits.
   always_comb begin
      ld_byte_s = 8'h00;
      ld_half_s = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
      ld_data_o = 32'h0000_0000;
      case (ld_addr_lo_i)
         2'b00:   ld_byte_s = ld_rdata_i[7:0];
         2'b01:   ld_byte_s = ld_rdata_i[15:8];
         2'b10:   ld_byte_s = ld_rdata_i[23:16];
         2'b11:   ld_byte_s = ld_rdata_i[31:24];
         default: ld_byte_s = 8'h00;
      endcase
      case (ld_size_i)
         SZ_BYTE: ld_data_o = {{24{ld_byte_s[7] & ~ld_unsigned_i}}, ld_byte_s};
         SZ_HALF: ld_data_o = {{16{ld_half_s[15] & ~ld_unsigned_i}}, ld_half_s};
         SZ_WORD: ld_data_o = ld_rdata_i;
         default: ld_data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one access at a time, places store lanes,
// runs the memory req/ack handshake with a timeout and returns load data.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned AW      = 10,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic          rsp_err,
   output logic [31:0]   rsp_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata
);

   localparam int unsigned   CW      = (TIMEOUT < 32'd1) ? 1 : $clog2(TIMEOUT + 32'd1);
   localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   lsu_state_e      state_q, state_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [1:0]      lo_q, lo_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]      mem_be_q, mem_be_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [31:0]     rsp_rdata_q, rsp_rdata_d;

   logic            accept_s;
   logic            bad_req_s;
   logic            timeout_s;
   logic [3:0]      st_be_s;
   logic [31:0]     st_wdata_s;
   logic [31:0]     ld_data_s;
   logic            unused_addr_s;

   assign req_ready     = (state_q == IDLE) && !rst;
   assign accept_s      = req_valid && req_ready;
   assign bad_req_s     = (req_size == SZ_ILLEGAL) || misaligned(req_size, req_addr[1:0]);
   assign timeout_s     = (TIMEOUT != 32'd0) && (wait_q == TO_CNT);
   assign unused_addr_s = ^req_addr[31:AW+2];

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

   // Store lanes come from the live request; load lanes from the registered fields.
   lsu_lane_align u_align (
      .st_size_i     (req_size),
      .st_addr_lo_i  (req_addr[1:0]),
      .st_wdata_i    (req_wdata),
      .st_be_o       (st_be_s),
      .st_wdata_o    (st_wdata_s),
      .ld_size_i     (size_q),
      .ld_addr_lo_i  (lo_q),
      .ld_unsigned_i (uns_q),
      .ld_rdata_i    (mem_rdata),
      .ld_data_o     (ld_data_s)
   );

   // Next-state and output logic; the response fields are single-cycle pulses.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lo_d        = lo_q;
      wait_d      = wait_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0000_0000;
      case (state_q)
         IDLE: begin
            if (accept_s && bad_req_s) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else if (accept_s) begin
               state_d     = REQ;
               we_d        = req_we;
               size_d      = req_size;
               uns_d       = req_unsigned;
               lo_d        = req_addr[1:0];
               wait_d      = {CW{1'b0}};
               mem_req_d   = 1'b1;
               mem_we_d    = req_we;
               mem_addr_d  = req_addr[AW+1:2];
               mem_be_d    = st_be_s;
               mem_wdata_d = st_wdata_s;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            // An ack in the same cycle the counter reaches the limit still completes cleanly.
            if (mem_ack) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? 32'h0000_0000 : ld_data_s;
            end else if (timeout_s) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else if (wait_q != CNT_MAX) begin
               wait_d = wait_q + CW'(1);
            end else begin
               wait_d = wait_q;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and request/response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lo_q        <= 2'b00;
         wait_q      <= {CW{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {AW{1'b0}};
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0000_0000;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lo_q        <= lo_d;
         wait_q      <= wait_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-level memory responder plus a
// shadow byte memory that predicts every response.
module tb_lsu_mem_ctrl;

   localparam int AW = 10;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata, mem_rdata;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         rsp_cyc = 0;
   bit         req_seen = 1'b0;
   logic [7:0] bmem [0:4095];
   logic [7:0] smem [0:4095];
   bit         model_en = 1'b0;
   int         ack_wait = 0;
   int         wctr = 0;
   logic       model_ack = 1'b0;
   logic       force_ack = 1'b0;

   assign mem_ack = model_ack | force_ack;

   lsu_mem_ctrl #(.AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: acks after ack_wait idle REQ cycles.
   always @(negedge clk) begin
      model_ack = 1'b0;
      mem_rdata = 32'h0;
      if (model_en && mem_req === 1'b1) begin
         if (wctr == ack_wait) begin
            model_ack = 1'b1;
            wctr = 0;
            if (mem_we) begin
               for (int i = 0; i < 4; i++)
                  if (mem_be[i]) bmem[{mem_addr, 2'(i)}] = mem_wdata[8*i +: 8];
            end else begin
               mem_rdata = {bmem[{mem_addr, 2'd3}], bmem[{mem_addr, 2'd2}],
                            bmem[{mem_addr, 2'd1}], bmem[{mem_addr, 2'd0}]};
            end
         end else begin
            wctr = wctr + 1;
         end
      end else begin
         wctr = 0;
      end
   end

   // Response monitor: pops the scoreboard on every rsp_valid.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (mem_req === 1'b1) req_seen = 1'b1;
      if (rsp_valid === 1'b1) begin
         rsp_cyc = cyc;
         total = total + 1;
         if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL rsp_unexpected got err=%0b rdata=%h want no response", rsp_err, rsp_rdata);
         end else begin
            e = exp_q.pop_front();
            if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
               bad = bad + 1;
               $display("FAIL rsp got err=%0b rdata=%h want err=%0b rdata=%h",
                        rsp_err, rsp_rdata, e.err, e.rdata);
            end
         end
      end
   end

   function automatic exp_t mk(input logic err, input logic [31:0] d);
      exp_t e;
      e.err = err;
      e.rdata = d;
      return e;
   endfunction

   function automatic logic [31:0] sh_load(input logic [1:0] size, input logic [31:0] addr, input logic uns);
      logic [11:0] a;
      logic [31:0] w;
      a = addr[11:0];
      w = {smem[a + 12'd3], smem[a + 12'd2], smem[a + 12'd1], smem[a]};
      case (size)
         2'b10:   return uns ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
         2'b01:   return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic sh_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
      int n;
      logic [11:0] a;
      a = addr[11:0];
      n = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
      for (int i = 0; i < n; i++) smem[a + 12'(i)] = wd[8*i +: 8];
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit keep,
                        output int acc);
      req_valid = 1'b1;
      req_we = we;
      req_size = size;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wd;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         if (req_ready === 1'b1) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL accept_timeout got ready=%0b want ready=1", req_ready);
      end
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      total = total + 1;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL %s_no_rsp got pending=%0d want pending=0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total = total + 1;
      if (req_ready !== 1'b0) begin
         bad = bad + 1;
         $display("FAIL ready_in_reset got %0b want 0", req_ready);
      end
      total = total + 1;
      if ({rsp_valid, rsp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
         bad = bad + 1;
         $display("FAIL reset_outputs got rv=%0b re=%0b mr=%0b mw=%0b be=%b ad=%h wd=%h rd=%h want all 0",
                  rsp_valid, rsp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_rdata);
      end
      rst = 1'b0;
      #1;
      total = total + 1;
      if (req_ready !== 1'b1) begin
         bad = bad + 1;
         $display("FAIL ready_after_reset got %0b want 1", req_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_store_byte();
      int acc;
      model_en = 1'b1;
      ack_wait = 3;
      exp_q.push_back(mk(1'b0, 32'h0));
      sh_store(2'b10, 32'h103, 32'hA5);
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_00A5, 1'b0, acc);
      total = total + 5;
      if (mem_req !== 1'b1) begin bad++; $display("FAIL sb_mem_req got %0b want 1", mem_req); end
      if (mem_we !== 1'b1) begin bad++; $display("FAIL sb_mem_we got %0b want 1", mem_we); end
      if (mem_addr !== 10'h040) begin bad++; $display("FAIL sb_mem_addr got %h want 040", mem_addr); end
      if (mem_be !== 4'b1000) begin bad++; $display("FAIL sb_mem_be got %b want 1000", mem_be); end
      if (mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_mem_wdata got %h want a5a5a5a5", mem_wdata); end
      wait_drain("store_byte");
      total = total + 1;
      if (rsp_cyc - acc !== 5) begin bad++; $display("FAIL sb_latency got %0d want 5", rsp_cyc - acc); end
   endtask

   task automatic test_load_half();
      int acc;
      logic [31:0] w;
      w = 32'h8001_1234;
      for (int i = 0; i < 4; i++) begin
         bmem[12'h100 + 12'(i)] = w[8*i +: 8];
         smem[12'h100 + 12'(i)] = w[8*i +: 8];
      end
      model_en = 1'b1;
      ack_wait = 1;
      exp_q.push_back(mk(1'b0, 32'hFFFF_8001));
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1'b0, acc);
      total = total + 2;
      if (mem_be !== 4'b1100) begin bad++; $display("FAIL lh_mem_be got %b want 1100", mem_be); end
      if (mem_we !== 1'b0) begin bad++; $display("FAIL lh_mem_we got %0b want 0", mem_we); end
      wait_drain("load_half");
      total = total + 1;
      if (rsp_cyc - acc !== 3) begin bad++; $display("FAIL lh_latency got %0d want 3", rsp_cyc - acc); end
      exp_q.push_back(mk(1'b0, 32'h0000_8001));
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1'b0, acc);
      wait_drain("load_hu");
      exp_q.push_back(mk(1'b0, 32'hFFFF_FF80));
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 1'b0, acc);
      wait_drain("load_b");
   endtask

   task automatic test_errors();
      int acc;
      logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz_t [3] = '{2'b00, 2'b01, 2'b11};
      logic [31:0] ad_t [3] = '{32'h102, 32'h101, 32'h100};
      for (int k = 0; k < 3; k++) begin
         req_seen = 1'b0;
         exp_q.push_back(mk(1'b1, 32'h0));
         issue(we_t[k], sz_t[k], 1'b0, ad_t[k], 32'hFFFF_FFFF, 1'b0, acc);
         total = total + 1;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL err%0d_n1 got valid=%0b err=%0b want 1/1", k, rsp_valid, rsp_err);
         end
         wait_drain("err");
         total = total + 1;
         if (rsp_cyc - acc !== 1) begin bad++; $display("FAIL err%0d_latency got %0d want 1", k, rsp_cyc - acc); end
         @(negedge clk);
         total = total + 1;
         if (req_seen !== 1'b0) begin bad++; $display("FAIL err%0d_mem_req got 1 want 0", k); end
      end
   endtask

   task automatic test_timeout();
      int acc;
      model_en = 1'b0;
      exp_q.push_back(mk(1'b1, 32'h0));
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 1'b0, acc);
      wait_drain("timeout");
      total = total + 2;
      if (rsp_cyc - acc !== TO + 2) begin bad++; $display("FAIL to_latency got %0d want %0d", rsp_cyc - acc, TO + 2); end
      if (mem_req !== 1'b0) begin bad++; $display("FAIL to_mem_req got %0b want 0", mem_req); end
      force_ack = 1'b1;
      @(negedge clk);
      total = total + 1;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL to_ready_late_ack got %0b want 1", req_ready); end
      @(negedge clk);
      force_ack = 1'b0;
      model_en = 1'b1;
      ack_wait = TO;
      exp_q.push_back(mk(1'b0, 32'h0));
      sh_store(2'b00, 32'h204, 32'hDEAD_BEEF);
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 1'b0, acc);
      wait_drain("ack_at_limit");
      total = total + 1;
      if (rsp_cyc - acc !== TO + 2) begin bad++; $display("FAIL limit_latency got %0d want %0d", rsp_cyc - acc, TO + 2); end
   endtask

   task automatic test_reset_mid();
      int acc;
      model_en = 1'b0;
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0300, 32'h1111_1111, 1'b0, acc);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total = total + 1;
      if ({mem_req, mem_we, rsp_valid, rsp_err, req_ready, mem_be, mem_addr, mem_wdata} !== '0) begin
         bad++;
         $display("FAIL rst_mid got mr=%0b mw=%0b rv=%0b re=%0b rdy=%0b be=%b ad=%h wd=%h want all 0",
                  mem_req, mem_we, rsp_valid, rsp_err, req_ready, mem_be, mem_addr, mem_wdata);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      model_en = 1'b1;
      ack_wait = 0;
      exp_q.push_back(mk(1'b0, sh_load(2'b00, 32'h204, 1'b0)));
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0204, 32'h0, 1'b0, acc);
      wait_drain("after_reset");
   endtask

   task automatic test_back_to_back();
      int acc1, acc2;
      model_en = 1'b1;
      ack_wait = 0;
      exp_q.push_back(mk(1'b0, 32'h0));
      sh_store(2'b00, 32'h3F8, 32'hCAFE_F00D);
      issue(1'b1, 2'b00, 1'b0, 32'h0000_03F8, 32'hCAFE_F00D, 1'b1, acc1);
      exp_q.push_back(mk(1'b0, sh_load(2'b00, 32'h3F8, 1'b0)));
      issue(1'b0, 2'b00, 1'b0, 32'h0000_03F8, 32'h0, 1'b0, acc2);
      total = total + 1;
      if (acc2 - acc1 !== 3) begin bad++; $display("FAIL b2b_spacing got %0d want 3", acc2 - acc1); end
      wait_drain("back_to_back");
   endtask

   task automatic test_random();
      int acc;
      logic [1:0]  sz;
      logic [31:0] a, d;
      logic        u;
      for (int k = 0; k < 10; k++) begin
         sz = 2'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 4095));
         if (sz == 2'b00) a[1:0] = 2'b00;
         if (sz == 2'b01) a[0] = 1'b0;
         d = $urandom;
         u = 1'($urandom_range(0, 1));
         ack_wait = $urandom_range(0, 2);
         exp_q.push_back(mk(1'b0, 32'h0));
         sh_store(sz, a, d);
         issue(1'b1, sz, 1'b0, a, d, 1'b0, acc);
         wait_drain("rand_store");
         exp_q.push_back(mk(1'b0, sh_load(sz, a, u)));
         issue(1'b0, sz, u, a, 32'h0, 1'b0, acc);
         wait_drain("rand_load");
         exp_q.push_back(mk(1'b0, sh_load(2'b00, {a[31:2], 2'b00}, 1'b0)));
         issue(1'b0, 2'b00, 1'b0, {a[31:2], 2'b00}, 32'h0, 1'b0, acc);
         wait_drain("rand_word");
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         bmem[i] = 8'h00;
         smem[i] = 8'h00;
      end
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      test_reset();
      test_store_byte();
      test_load_half();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (3) @(negedge clk);
      total = total + 1;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL final_queue got pending=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
